// File: rtl/aq_ifu_ras_pred_if.sv
// Redirect handshake between the RAS predictor and instruction fetch.
// Also carries the decode stall back-pressure.
interface aq_ifu_ras_pred_if;
  logic        pred_ifu_redir_vld;
  logic [23:0] pred_ifu_redir_pc;
  logic        ifu_pred_redir_rdy;
  logic        pred_ipd_stall;

  modport master (
    output pred_ifu_redir_vld,
    output pred_ifu_redir_pc,
    output pred_ipd_stall,
    input  ifu_pred_redir_rdy
  );

  modport slave (
    input  pred_ifu_redir_vld,
    input  pred_ifu_redir_pc,
    input  pred_ipd_stall,
    output ifu_pred_redir_rdy
  );
endinterface

// File: rtl/aq_ifu_ras_pred.sv
// Return-address-stack predictor control: push/pop issue, speculative/commit depth tracking, fetch redirect.
// Optional macro AQ_IFU_RAS_PRED_RVC_EN enables 16-bit call return offsets.
//
// state   | meaning
// S_IDLE  | no redirect outstanding
// S_REDIR | redirect to captured return target waiting for fetch ready
module aq_ifu_ras_pred (
  input  logic        ras_cpuclk,
  input  logic        cpurst_b,
  input  logic        ipd_call_vld,
  input  logic        ipd_ret_vld,
  input  logic [23:0] ipd_pc,
  input  logic        ipd_inst_32,
  input  logic [23:0] ras_pred_tar_pc,
  output logic        pred_ras_link_vld,
  output logic        pred_ras_ret_vld,
  output logic [23:0] pred_ras_link_pc,
  output logic        ras_cur_st,
  input  logic        rtu_ifu_flush_fe,
  input  logic        iu_ifu_bht_mispred,
  input  logic        iu_ifu_pc_mispred,
  input  logic        iu_ifu_link_vld,
  input  logic        iu_ifu_ret_vld,
  aq_ifu_ras_pred_if.master redir_if
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_REDIR = 1'b1
  } ras_st_e;

  localparam logic [2:0] CNT_MAX = 3'd4;

  ras_st_e     r_state;
  ras_st_e     w_state_nxt;
  logic [2:0]  r_spec_cnt;
  logic [2:0]  w_spec_cnt_nxt;
  logic [2:0]  r_commit_cnt;
  logic [2:0]  w_commit_cnt_nxt;
  logic [23:0] r_redir_pc;
  logic        w_restore;
  logic        w_stall;
  logic        w_accept;
  logic        w_capture;
  logic [23:0] w_link_ofs;

  // A pc mispredict that itself is a link keeps the speculative depth.
  assign w_restore = rtu_ifu_flush_fe | iu_ifu_bht_mispred
                   | (iu_ifu_pc_mispred & ~iu_ifu_link_vld);
  assign w_stall   = (r_state == S_REDIR) & ~redir_if.ifu_pred_redir_rdy;
  assign w_accept  = ~w_restore & ~w_stall;

  assign pred_ras_link_vld = ipd_call_vld & w_accept;
  assign pred_ras_ret_vld  = ipd_ret_vld & ~ipd_call_vld & w_accept;

`ifdef AQ_IFU_RAS_PRED_RVC_EN
  assign w_link_ofs = ipd_inst_32 ? 24'd4 : 24'd2;
`else
  logic w_unused_inst_32;
  assign w_unused_inst_32 = ipd_inst_32;
  assign w_link_ofs       = 24'd4;
`endif

  assign pred_ras_link_pc = ipd_pc + w_link_ofs;

  assign ras_cur_st = (r_spec_cnt == 3'd0);
  assign w_capture  = pred_ras_ret_vld & ~ras_cur_st;

  always_comb begin
    w_spec_cnt_nxt = r_spec_cnt;
    if (w_restore) begin
      w_spec_cnt_nxt = r_commit_cnt;
    end else if (pred_ras_link_vld) begin
      if (r_spec_cnt != CNT_MAX) begin
        w_spec_cnt_nxt = r_spec_cnt + 3'd1;
      end
    end else if (pred_ras_ret_vld) begin
      if (r_spec_cnt != 3'd0) begin
        w_spec_cnt_nxt = r_spec_cnt - 3'd1;
      end
    end
  end

  always_comb begin
    w_commit_cnt_nxt = r_commit_cnt;
    if (iu_ifu_link_vld & ~rtu_ifu_flush_fe) begin
      if (r_commit_cnt != CNT_MAX) begin
        w_commit_cnt_nxt = r_commit_cnt + 3'd1;
      end
    end else if (iu_ifu_ret_vld & ~rtu_ifu_flush_fe) begin
      if (r_commit_cnt != 3'd0) begin
        w_commit_cnt_nxt = r_commit_cnt - 3'd1;
      end
    end
  end

  // A capture can only occur when not restoring, so it cannot collide with a drop.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_capture) begin
          w_state_nxt = S_REDIR;
        end
      end
      S_REDIR: begin
        if (w_capture) begin
          w_state_nxt = S_REDIR;
        end else if (w_restore | redir_if.ifu_pred_redir_rdy) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ras_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state      <= S_IDLE;
      r_spec_cnt   <= 3'd0;
      r_commit_cnt <= 3'd0;
      r_redir_pc   <= 24'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_spec_cnt   <= w_spec_cnt_nxt;
      r_commit_cnt <= w_commit_cnt_nxt;
      if (w_capture) begin
        r_redir_pc <= ras_pred_tar_pc;
      end
    end
  end

  assign redir_if.pred_ifu_redir_vld = (r_state == S_REDIR);
  assign redir_if.pred_ifu_redir_pc  = r_redir_pc;
  assign redir_if.pred_ipd_stall     = w_stall;

endmodule

// File: tb/tb_aq_ifu_ras_pred.sv
// Directed bench for aq_ifu_ras_pred with a per-cycle reference model of stack depth and redirect.
module tb_aq_ifu_ras_pred;
  logic        clk = 1'b0;
  logic        rst_b;
  logic        call, ret, inst32;
  logic [23:0] pc, tar;
  logic        flush, bht, pcm, ilink, iret;
  logic        link_vld, ret_vld, cur_st;
  logic [23:0] link_pc;

  aq_ifu_ras_pred_if rif ();

  aq_ifu_ras_pred dut (
    .ras_cpuclk        (clk),
    .cpurst_b          (rst_b),
    .ipd_call_vld      (call),
    .ipd_ret_vld       (ret),
    .ipd_pc            (pc),
    .ipd_inst_32       (inst32),
    .ras_pred_tar_pc   (tar),
    .pred_ras_link_vld (link_vld),
    .pred_ras_ret_vld  (ret_vld),
    .pred_ras_link_pc  (link_pc),
    .ras_cur_st        (cur_st),
    .rtu_ifu_flush_fe  (flush),
    .iu_ifu_bht_mispred(bht),
    .iu_ifu_pc_mispred (pcm),
    .iu_ifu_link_vld   (ilink),
    .iu_ifu_ret_vld    (iret),
    .redir_if          (rif.master)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_redir = 0;
  int base;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: stack depths as integers, one pending redirect slot.
  int          m_spec, m_commit;
  bit          m_pend;
  logic [23:0] m_pc;

  function automatic bit f_restore();
    return flush | bht | (pcm & !ilink);
  endfunction
  function automatic bit f_accept();
    return !f_restore() && !(m_pend && !rif.ifu_pred_redir_rdy);
  endfunction
  function automatic logic [23:0] f_link_pc();
    int ofs;
`ifdef AQ_IFU_RAS_PRED_RVC_EN
    ofs = inst32 ? 4 : 2;
`else
    ofs = 4;
`endif
    return 24'((int'(pc) + ofs) % (1 << 24));
  endfunction

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_spec = 0; m_commit = 0; m_pend = 0; m_pc = 24'd0;
    end else begin
      bit rs, lk, rt;
      int ns;
      rs = f_restore();
      lk = call && f_accept();
      rt = ret && !call && f_accept();
      ns = m_spec;
      if (rs) ns = m_commit;
      else if (lk) ns = (m_spec < 4) ? m_spec + 1 : 4;
      else if (rt && m_spec > 0) ns = m_spec - 1;
      if (ilink && !flush) m_commit = (m_commit < 4) ? m_commit + 1 : 4;
      else if (iret && !flush && m_commit > 0) m_commit = m_commit - 1;
      if (rt && m_spec != 0) begin
        m_pend = 1; m_pc = tar;
      end else if (m_pend && (rs || rif.ifu_pred_redir_rdy)) begin
        m_pend = 0;
      end
      m_spec = ns;
    end
  end

  always @(negedge clk) begin
    chk("link_vld", 32'(link_vld), 32'(call && f_accept()));
    chk("ret_vld",  32'(ret_vld),  32'(ret && !call && f_accept()));
    chk("link_pc",  32'(link_pc),  32'(f_link_pc()));
    chk("cur_st",   32'(cur_st),   32'(m_spec == 0));
    chk("redir_vld", 32'(rif.pred_ifu_redir_vld), 32'(m_pend));
    chk("redir_pc", 32'(rif.pred_ifu_redir_pc), 32'(m_pc));
    chk("stall",    32'(rif.pred_ipd_stall), 32'(m_pend && !rif.ifu_pred_redir_rdy));
    if (rif.pred_ifu_redir_vld && rif.ifu_pred_redir_rdy) n_redir++;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic settle();
    #1;
  endtask

  initial begin
    rst_b = 1'b0;
    {call, ret, inst32, flush, bht, pcm, ilink, iret} = '0;
    pc = 24'd0; tar = 24'd0;
    rif.ifu_pred_redir_rdy = 1'b1;
    tick(2);
    chk("rst cur_st", 32'(cur_st), 32'd1);
    chk("rst redir_vld", 32'(rif.pred_ifu_redir_vld), 32'd0);
    chk("rst redir_pc", 32'(rif.pred_ifu_redir_pc), 32'd0);
    chk("rst stall", 32'(rif.pred_ipd_stall), 32'd0);
    rst_b = 1'b1;
    tick();

    // ret while empty
    ret = 1; pc = 24'h000100; settle();
    chk("empty ret_vld", 32'(ret_vld), 32'd1);
    chk("empty cur_st", 32'(cur_st), 32'd1);
    tick(); ret = 0; settle();
    chk("empty no redir", 32'(rif.pred_ifu_redir_vld), 32'd0);
    chk("empty still 0", 32'(cur_st), 32'd1);

    // call then ret with redirect
    call = 1; inst32 = 1; pc = 24'h001000; settle();
    chk("call link_pc", 32'(link_pc), 32'h001004);
    tick(); call = 0; tar = 24'h001004; settle();
    chk("after call cur_st", 32'(cur_st), 32'd0);
    ret = 1; tick(); ret = 0; settle();
    chk("redir vld", 32'(rif.pred_ifu_redir_vld), 32'd1);
    chk("redir pc", 32'(rif.pred_ifu_redir_pc), 32'h001004);
    chk("after ret cur_st", 32'(cur_st), 32'd1);
    tick();

    // call beats ret
    call = 1; ret = 1; pc = 24'h000200; settle();
    chk("both ret_vld", 32'(ret_vld), 32'd0);
    chk("both link_vld", 32'(link_vld), 32'd1);
    tick(); call = 0; ret = 1; tick(); ret = 0; tick(2);

    // five calls saturate, five rets give four redirects
    base = n_redir;
    call = 1;
    for (int i = 0; i < 5; i++) begin pc = 24'h002000 + 24'(i * 16); tick(); end
    call = 0; ret = 1;
    for (int i = 0; i < 5; i++) begin
      tar = 24'h002100 + 24'(i);
      settle();
      if (i == 4) chk("fifth ret empty", 32'(cur_st), 32'd1);
      tick();
    end
    ret = 0; tick(3);
    chk("redirect count", 32'(n_redir - base), 32'd4);

    // redirect held off by rdy=0 with a call waiting
    call = 1; pc = 24'h003000; tick(); call = 0;
    tar = 24'h003004; ret = 1; rif.ifu_pred_redir_rdy = 0; tick(); ret = 0;
    call = 1; pc = 24'h004000;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("hold stall", 32'(rif.pred_ipd_stall), 32'd1);
      chk("hold pc", 32'(rif.pred_ifu_redir_pc), 32'h003004);
      chk("hold no link", 32'(link_vld), 32'd0);
      tick();
    end
    rif.ifu_pred_redir_rdy = 1; settle();
    chk("release link", 32'(link_vld), 32'd1);
    chk("release stall", 32'(rif.pred_ipd_stall), 32'd0);
    tick(); call = 0;

    // restore to commit depth
    flush = 1; tick(); flush = 0;
    ilink = 1; tick(); ilink = 0;
    call = 1; tick(3); call = 0;
    pcm = 1; call = 1; settle();
    chk("restore blocks link", 32'(link_vld), 32'd0);
    tick(); pcm = 0; call = 0; settle();
    chk("restored to 1", 32'(cur_st), 32'd0);
    ret = 1; tick(); ret = 0; settle();
    chk("restored depth 1 empty", 32'(cur_st), 32'd1);
    tick();
    call = 1; tick(3); call = 0;
    pcm = 1; ilink = 1; tick(); pcm = 0; ilink = 0;
    ret = 1; tick(2); settle();
    chk("link mispred keeps depth", 32'(cur_st), 32'd0);
    tick(); ret = 0; settle();
    chk("depth 3 drained", 32'(cur_st), 32'd1);
    tick();

    // restore while redirect pending drops it
    call = 1; tick(); call = 0;
    ret = 1; rif.ifu_pred_redir_rdy = 0; tick(); ret = 0;
    flush = 1; tick(); flush = 0; settle();
    chk("flush drops redir", 32'(rif.pred_ifu_redir_vld), 32'd0);
    chk("flush loads commit", 32'(cur_st), 32'd0);
    rif.ifu_pred_redir_rdy = 1;
    iret = 1; tick(2); iret = 0;
    flush = 1; tick(); flush = 0; settle();
    chk("commit drained", 32'(cur_st), 32'd1);

    // link pc wrap
    call = 1; pc = 24'hFFFFFE; inst32 = 0; settle();
`ifdef AQ_IFU_RAS_PRED_RVC_EN
    chk("wrap rvc", 32'(link_pc), 32'h000000);
`else
    chk("wrap norvc", 32'(link_pc), 32'h000002);
`endif
    inst32 = 1; settle();
    chk("wrap 32", 32'(link_pc), 32'h000002);
    tick(); call = 0; tick(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/aq_ifu_ras_pred.md
AQ_IFU_RAS_PRED -- requirements
Module: aq_ifu_ras_pred

Interface
REQ-001 SHALL have these ports, clock and reset first: ras_cpuclk input 1, clock; cpurst_b input 1, reset (asynchronous, active-low).
REQ-002 SHALL have these decode inputs: ipd_call_vld input 1, decoded call (link); ipd_ret_vld input 1, decoded return; ipd_pc input 24, low 24 bits of the call/ret instruction PC; ipd_inst_32 input 1, instruction is 32-bit.
REQ-003 SHALL have these RAS-side ports: ras_pred_tar_pc input 24, RAS top-of-stack target; pred_ras_link_vld output 1, push; pred_ras_ret_vld output 1, pop; pred_ras_link_pc output 24, pushed return address; ras_cur_st output 1, 1 means stack speculatively empty (pop pointer frozen).
REQ-004 SHALL have these flush and commit inputs, each 1 bit: rtu_ifu_flush_fe, iu_ifu_bht_mispred, iu_ifu_pc_mispred, iu_ifu_link_vld, iu_ifu_ret_vld.
REQ-005 SHALL have these fetch redirect ports: pred_ifu_redir_vld output 1; pred_ifu_redir_pc output 24; ifu_pred_redir_rdy input 1; pred_ipd_stall output 1, decode must hold call/ret.

Function
REQ-006 SHALL define restore = rtu_ifu_flush_fe | iu_ifu_bht_mispred | (iu_ifu_pc_mispred & !iu_ifu_link_vld).
REQ-007 SHALL define accept = !restore & !pred_ipd_stall.
- pred_ras_link_vld = ipd_call_vld & accept.
- pred_ras_ret_vld = ipd_ret_vld & !ipd_call_vld & accept.
- Call wins when both are asserted; the ret is dropped.
REQ-008 SHALL compute pred_ras_link_pc = ipd_pc + 4, or + 2 per REQ-020, modulo 2^24, combinationally.
REQ-009 SHALL keep spec_cnt (3 bits, range 0..4).
- On link: saturating increment to 4.
- On ret: decrement when nonzero.
- On restore: load commit_cnt (its value before this cycle's update).
- Otherwise hold.
REQ-010 SHALL keep commit_cnt (range 0..4).
- On iu_ifu_link_vld & !rtu_ifu_flush_fe: saturating increment.
- Else on iu_ifu_ret_vld & !rtu_ifu_flush_fe: decrement when nonzero.
- Link has priority over ret.
REQ-011 SHALL drive ras_cur_st = (spec_cnt == 0) combinationally from the register.
REQ-012 SHALL use a 2-state redirect FSM, IDLE and REDIR.
- IDLE->REDIR: pred_ras_ret_vld & !ras_cur_st. In that cycle, capture ras_pred_tar_pc (pre-pop value) into redir_pc.
- REDIR->IDLE: ifu_pred_redir_rdy, or restore. Restore wins over a new capture.
REQ-013 SHALL assert pred_ifu_redir_vld only in REDIR.
- First assertion is 1 cycle after the ret.
- pred_ifu_redir_pc holds stable while pred_ifu_redir_vld & !ifu_pred_redir_rdy.
REQ-014 SHALL drive pred_ipd_stall = REDIR & !ifu_pred_redir_rdy.
REQ-015 SHALL NOT produce a redirect for a ret taken while empty. pred_ras_ret_vld still pulses; spec_cnt stays 0.
REQ-016 SHALL NOT issue link/ret in any restore cycle. A restore while in REDIR drops the pending redirect with no handshake.

Reset
REQ-017 SHALL on cpurst_b low asynchronously set:
- spec_cnt = 0 and commit_cnt = 0;
- FSM to IDLE;
- redir_pc = 0.
REQ-018 SHALL after reset output: ras_cur_st=1, pred_ifu_redir_vld=0, pred_ifu_redir_pc=0, pred_ipd_stall=0.
REQ-019 SHALL allow the combinational outputs pred_ras_link_vld, pred_ras_ret_vld and pred_ras_link_pc to follow their inputs during reset.

Configuration
REQ-020 SHALL support macro AQ_IFU_RAS_PRED_RVC_EN.
- Defined: link offset = ipd_inst_32 ? 4 : 2.
- Undefined: offset is always 4 and ipd_inst_32 is unused.

Verification
REQ-021 Reset, then ret at pc 0x000100:
- pred_ras_ret_vld=1, ras_cur_st=1;
- no redir_vld; spec_cnt stays 0.
REQ-022 Call at 0x001000 (32-bit), then ras_pred_tar_pc=0x001004, then ret with rdy=1:
- link_pc=0x001004;
- redir_vld=1 with pc=0x001004 one cycle after the ret;
- spec_cnt 1->0.
REQ-023 Five calls:
- spec_cnt saturates at 4;
- after five rets only four redirects occur; the fifth ret has ras_cur_st=1.
REQ-024 Redirect pending with rdy=0 for 3 cycles, and a call presented meanwhile:
- stall=1 and redir_pc stable for 3 cycles;
- no pred_ras_link_vld until rdy=1.
REQ-025 commit_cnt=1, spec_cnt=3, then iu_ifu_pc_mispred=1 with iu_ifu_link_vld=0:
- next cycle spec_cnt=1;
- the same pulse with iu_ifu_link_vld=1 leaves spec_cnt unchanged.
REQ-026 With RVC_EN, call at 0xFFFFFE with ipd_inst_32=0 gives link_pc=0x000000 (wrap); without RVC_EN the result is 0x000002.
